mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_ni  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr_i  in  32  instruction register contents, stable from DECODE onward.
REQ-004 SHALL have ports: mem_ready_i  in  1  memory completes the current request this cycle.
REQ-005 SHALL have ports: br_taken_i  in  1  branch comparator result, valid in EXEC.
REQ-006 SHALL have ports: mem_req_o  out  1; mem_we_o  out  1; ir_en_o  out  1; pc_en_o  out  1; rd_wren_o  out  1.
REQ-007 SHALL have ports: pc_sel_o  out  2 (PLUS4/BRANCH/JAL/JALR); wb_sel_o  out  2 (ALU/MEM/PC4); opa_sel_o  out  1 (RS1/PC); opb_sel_o  out  1 (RS2/IMM); alu_op_o  out  4.
REQ-008 SHALL have ports: state_o  out  3  current state; illegal_o  out  1  sticky trap flag.
REQ-009 SHALL have ports: cycle_cnt_o  out  32; instret_o  out  32 (see Configuration).

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs are decoded from state and instr_i.
REQ-011 SHALL move IDLE->FETCH unconditionally on the first clock after reset release.
REQ-012 FETCH SHALL assert mem_req_o and hold until mem_ready_i; in the ready cycle it SHALL pulse ir_en_o and go to DECODE; a same-cycle ready gives a 1-cycle FETCH.
REQ-013 DECODE SHALL classify instr_i[6:2] as R 01100, I 00100, LOAD 00000, STORE 01000, BRANCH 11000, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001; any other class, or instr_i[1:0]!=2'b11, SHALL go to TRAP, else EXEC.
REQ-014 EXEC SHALL drive opa_sel_o/opb_sel_o/alu_op_o per class: R and I use funct3 plus funct7[5] (SUB for R only, SRA for R and I); LOAD/STORE/AUIPC/JAL/JALR use ADD; BRANCH uses SUB; LUI uses PASS_B.
REQ-015 EXEC SHALL go to MEM for LOAD/STORE, and to WB for R/I/LUI/AUIPC/JAL/JALR.
REQ-016 For BRANCH, EXEC SHALL pulse pc_en_o with pc_sel_o=BRANCH if br_taken_i else PLUS4, then go to FETCH.
REQ-017 MEM SHALL assert mem_req_o (mem_we_o=1 only for STORE) until mem_ready_i.
REQ-018 On MEM completion, STORE SHALL pulse pc_en_o (PLUS4) and go to FETCH; LOAD SHALL go to WB.
REQ-019 WB SHALL pulse rd_wren_o only if instr_i[11:7]!=0, and SHALL pulse pc_en_o.
REQ-020 WB SHALL drive pc_sel_o JAL/JALR for those classes else PLUS4, and wb_sel_o MEM for LOAD, PC4 for JAL/JALR, else ALU; it then goes to FETCH.
REQ-021 Latency with mem_ready_i tied high: R/I/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3, counted FETCH to the pc_en_o cycle inclusive.
REQ-022 TRAP SHALL hold illegal_o=1 with all enables low until reset; exactly one pc_en_o pulse SHALL occur per retired instruction.

Reset
REQ-023 rst_ni low SHALL force state IDLE immediately, without waiting for a clock edge.
REQ-024 While rst_ni is low, every output SHALL be 0, including both counters; a request in flight is abandoned, with mem_req_o dropping asynchronously.

Configuration
REQ-025 With MC_CTRL_PERF_EN defined, cycle_cnt_o SHALL increment every non-reset cycle, and instret_o SHALL increment on each pc_en_o pulse; both wrap 0xFFFFFFFF->0.
REQ-026 Without MC_CTRL_PERF_EN, the counter ports SHALL remain and be tied to 0, with no counter flops.

Structure
REQ-027 Package mc_pkg SHALL hold the state enum, opcode-class constants, and the alu_op, pc_sel, and wb_sel encodings.
REQ-028 Combinational class/ALU decode SHALL be sub-module mc_decode; the FSM and counters stay in mc_ctrl.

Verification
REQ-029 ADD 0x002081B3 with ready=1 -> IDLE,FETCH,DECODE,EXEC,WB,FETCH; rd_wren_o=1 and pc_en_o=1 only in WB; alu_op=ADD, wb_sel=ALU.
REQ-030 LW 0x0080A283 with ready low 3 MEM cycles -> mem_req_o high 4 MEM cycles with mem_we_o=0; WB with wb_sel=MEM and rd_wren_o=1.
REQ-031 SW 0x0050A423 -> mem_we_o=1 in MEM; pc_en_o pulse at completion; rd_wren_o never asserted.
REQ-032 BEQ 0x00208463 with br_taken_i=1 -> pc_sel_o=BRANCH and pc_en_o pulse in EXEC, next state FETCH; with br_taken_i=0 -> PLUS4.
REQ-033 Fetch 0xFFFFFFFF -> TRAP, illegal_o=1 for 10+ cycles; rst_ni low -> all outputs 0 at once, including the counters when MC_CTRL_PERF_EN is defined.
REQ-034 Assert rst_ni low mid-MEM with mem_req_o=1 -> mem_req_o=0 without a clock edge; after release, state IDLE then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle control unit.
// States, opcode classes, ALU ops, PC and writeback selects.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R      = 4'd0,
    C_I      = 4'd1,
    C_LOAD   = 4'd2,
    C_STORE  = 4'd3,
    C_BRANCH = 4'd4,
    C_LUI    = 4'd5,
    C_AUIPC  = 4'd6,
    C_JAL    = 4'd7,
    C_JALR   = 4'd8,
    C_ILL    = 4'd9
  } cls_t;

  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_I      = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic OPA_RS1 = 1'b0;
  localparam logic OPA_PC  = 1'b1;
  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  // funct3 to ALU op; SUB only for R, SRA for both R and I
  function automatic logic [3:0] alu_f3(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_r
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'd0: op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      3'd7: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction class and ALU operand decode.
// Pure function of the opcode, funct3 and funct7[5] fields.
module mc_decode
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] f3_i,
  input  logic       f7b5_i,
  output cls_t       cls_o,
  output logic [3:0] alu_op_o,
  output logic       opa_sel_o,
  output logic       opb_sel_o
);

  // classify the major opcode; wrong low bits are illegal
  always_comb begin
    cls_o = C_ILL;
    if (op_i[1:0] == 2'b11) begin
      unique case (op_i[6:2])
        OPC_R:      cls_o = C_R;
        OPC_I:      cls_o = C_I;
        OPC_LOAD:   cls_o = C_LOAD;
        OPC_STORE:  cls_o = C_STORE;
        OPC_BRANCH: cls_o = C_BRANCH;
        OPC_LUI:    cls_o = C_LUI;
        OPC_AUIPC:  cls_o = C_AUIPC;
        OPC_JAL:    cls_o = C_JAL;
        OPC_JALR:   cls_o = C_JALR;
        default:    cls_o = C_ILL;
      endcase
    end
  end

  // per-class ALU op and operand sources
  always_comb begin
    alu_op_o  = ALU_ADD;
    opa_sel_o = OPA_RS1;
    opb_sel_o = OPB_RS2;
    case (cls_o)
      C_R: alu_op_o = alu_f3(f3_i, f7b5_i, 1'b1);
      C_I: begin
        alu_op_o  = alu_f3(f3_i, f7b5_i, 1'b0);
        opb_sel_o = OPB_IMM;
      end
      C_LOAD, C_STORE, C_JALR: opb_sel_o = OPB_IMM;
      C_BRANCH: alu_op_o = ALU_SUB;
      C_LUI: begin
        alu_op_o  = ALU_PASS_B;
        opb_sel_o = OPB_IMM;
      end
      C_AUIPC, C_JAL: begin
        opa_sel_o = OPA_PC;
        opb_sel_o = OPB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM with optional perf counters.
// Define MC_CTRL_PERF_EN to build the cycle and instret counters.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        br_taken_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_en_o,
  output logic        pc_en_o,
  output logic        rd_wren_o,
  output logic [1:0]  pc_sel_o,
  output logic [1:0]  wb_sel_o,
  output logic        opa_sel_o,
  output logic        opb_sel_o,
  output logic [3:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic        illegal_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
);

  state_t     st, nxt;
  cls_t       cls;
  logic [3:0] dec_alu;
  logic       dec_opa;
  logic       dec_opb;
  logic       unused_bits;

  assign unused_bits = ^{instr_i[31], instr_i[29:15]};

  mc_decode u_dec (
    .op_i      (instr_i[6:0]),
    .f3_i      (instr_i[14:12]),
    .f7b5_i    (instr_i[30]),
    .cls_o     (cls),
    .alu_op_o  (dec_alu),
    .opa_sel_o (dec_opa),
    .opb_sel_o (dec_opb)
  );

  // state register; reset lands in IDLE at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= S_IDLE;
    else         st <= nxt;
  end

  // next state and all control outputs; IDLE drives everything low
  always_comb begin
    nxt       = st;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_en_o   = 1'b0;
    pc_en_o   = 1'b0;
    rd_wren_o = 1'b0;
    pc_sel_o  = PC_PLUS4;
    wb_sel_o  = WB_ALU;
    opa_sel_o = OPA_RS1;
    opb_sel_o = OPB_RS2;
    alu_op_o  = ALU_ADD;
    unique case (st)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_en_o = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: nxt = (cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        opa_sel_o = dec_opa;
        opb_sel_o = dec_opb;
        alu_op_o  = dec_alu;
        case (cls)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_BRANCH: begin
            pc_en_o  = 1'b1;
            pc_sel_o = br_taken_i ? PC_BRANCH : PC_PLUS4;
            nxt      = S_FETCH;
          end
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cls == C_STORE);
        if (mem_ready_i) begin
          if (cls == C_STORE) begin
            pc_en_o = 1'b1;
            nxt     = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rd_wren_o = |instr_i[11:7];
        pc_en_o   = 1'b1;
        case (cls)
          C_JAL: begin
            pc_sel_o = PC_JAL;
            wb_sel_o = WB_PC4;
          end
          C_JALR: begin
            pc_sel_o = PC_JALR;
            wb_sel_o = WB_PC4;
          end
          C_LOAD:  wb_sel_o = WB_MEM;
          default: wb_sel_o = WB_ALU;
        endcase
        nxt = S_FETCH;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  assign state_o   = st;
  assign illegal_o = (st == S_TRAP);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  // free-running cycle count and retired-instruction count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (pc_en_o) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cyc_q;
  assign instret_o   = ret_q;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of the mc_ctrl FSM.
// Counter expectations follow MC_CTRL_PERF_EN when defined.
module tb_mc_ctrl;

`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic        ready = 1'b1;
  logic        br = 1'b0;
  logic        mem_req, mem_we, ir_en, pc_en, rd_wren;
  logic [1:0]  pc_sel, wb_sel;
  logic        opa, opb;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] cyc, ret;
  logic [31:0] ctl;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int nret = 0;

  mc_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .instr_i     (instr),
    .mem_ready_i (ready),
    .br_taken_i  (br),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .ir_en_o     (ir_en),
    .pc_en_o     (pc_en),
    .rd_wren_o   (rd_wren),
    .pc_sel_o    (pc_sel),
    .wb_sel_o    (wb_sel),
    .opa_sel_o   (opa),
    .opb_sel_o   (opb),
    .alu_op_o    (alu_op),
    .state_o     (state),
    .illegal_o   (illegal),
    .cycle_cnt_o (cyc),
    .instret_o   (ret)
  );

  always #5 clk = ~clk;

  assign ctl = {15'd0, mem_req, mem_we, ir_en, pc_en, rd_wren,
                pc_sel, wb_sel, opa, opb, alu_op, illegal};

  function automatic logic [31:0] cv(
    input logic req, we, ir, pc, rd,
    input logic [1:0] ps, ws,
    input logic oa, ob,
    input logic [3:0] alu,
    input logic ill
  );
    return {15'd0, req, we, ir, pc, rd, ps, ws, oa, ob, alu, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic look(input string tag, input int st,
                      input logic [31:0] c);
    check({tag, ".st"}, {29'd0, state}, 32'(st));
    check({tag, ".ctl"}, ctl, c);
  endtask

  task automatic cnt(input string tag);
    check({tag, ".cyc"}, cyc, PERF ? 32'(ncyc) : 32'd0);
    check({tag, ".ret"}, ret, PERF ? 32'(nret) : 32'd0);
  endtask

  // from a FETCH negedge: fetch and decode, ending at EXEC/TRAP
  task automatic fd(input string tag, input logic [31:0] v);
    instr = v;
    ready = 1'b1;
    look({tag, ".f"}, 1, cv(1,0,1,0,0,0,0,0,0,4'd0,0));
    step();
    look({tag, ".d"}, 2, 32'd0);
    step();
  endtask

  // register-writing instruction: EXEC, WB, back to FETCH
  task automatic run_wb(input string tag, input logic [31:0] v,
                        input logic [31:0] ex, input logic [31:0] wb);
    fd(tag, v);
    look({tag, ".e"}, 3, ex);
    step();
    look({tag, ".w"}, 5, wb);
    nret++;
    step();
    check({tag, ".nx"}, {29'd0, state}, 32'd1);
    cnt(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    look({tag, ".on"}, 0, 32'd0);
    check({tag, ".cyc0"}, cyc, 32'd0);
    check({tag, ".ret0"}, ret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ncyc = 0;
    nret = 0;
    #1;
    check({tag, ".idle"}, {29'd0, state}, 32'd0);
    step();
    check({tag, ".fetch"}, {29'd0, state}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    look("rst", 0, 32'd0);
    cnt("rst");
    rst_n = 1'b1;
    #1;
    check("rel.idle", {29'd0, state}, 32'd0);
    step();

    run_wb("add", 32'h0020_81B3,
           cv(0,0,0,0,0,0,0,0,0,4'd0,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));

    fd("lw", 32'h0080_A283);
    look("lw.e", 3, cv(0,0,0,0,0,0,0,0,1,4'd0,0));
    ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ready = 1'b1;
      look("lw.m", 4, cv(1,0,0,0,0,0,0,0,0,4'd0,0));
      step();
    end
    look("lw.w", 5, cv(0,0,0,1,1,0,1,0,0,4'd0,0));
    nret++;
    step();
    cnt("lw");

    fd("sw", 32'h0050_A423);
    look("sw.e", 3, cv(0,0,0,0,0,0,0,0,1,4'd0,0));
    step();
    look("sw.m", 4, cv(1,1,0,1,0,0,0,0,0,4'd0,0));
    nret++;
    step();
    check("sw.nx", {29'd0, state}, 32'd1);
    cnt("sw");

    br = 1'b1;
    fd("beqt", 32'h0020_8463);
    look("beqt.e", 3, cv(0,0,0,1,0,2'd1,0,0,0,4'd1,0));
    nret++;
    step();
    check("beqt.nx", {29'd0, state}, 32'd1);
    br = 1'b0;
    fd("beqn", 32'h0020_8463);
    look("beqn.e", 3, cv(0,0,0,1,0,2'd0,0,0,0,4'd1,0));
    nret++;
    step();
    check("beqn.nx", {29'd0, state}, 32'd1);
    cnt("beq");

    run_wb("sub", 32'h4020_81B3,
           cv(0,0,0,0,0,0,0,0,0,4'd1,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("sra", 32'h4020_D1B3,
           cv(0,0,0,0,0,0,0,0,0,4'd7,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("srai", 32'h4020_D193,
           cv(0,0,0,0,0,0,0,0,1,4'd7,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("addi", 32'h4000_8193,
           cv(0,0,0,0,0,0,0,0,1,4'd0,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("xor", 32'h0020_C1B3,
           cv(0,0,0,0,0,0,0,0,0,4'd5,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("and", 32'h0020_F1B3,
           cv(0,0,0,0,0,0,0,0,0,4'd9,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("lui", 32'h1234_50B7,
           cv(0,0,0,0,0,0,0,0,1,4'd10,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("auipc", 32'h0000_1297,
           cv(0,0,0,0,0,0,0,1,1,4'd0,0),
           cv(0,0,0,1,1,0,0,0,0,4'd0,0));
    run_wb("jal", 32'h0000_00EF,
           cv(0,0,0,0,0,0,0,1,1,4'd0,0),
           cv(0,0,0,1,1,2'd2,2'd2,0,0,4'd0,0));
    run_wb("jalr", 32'h0001_00E7,
           cv(0,0,0,0,0,0,0,0,1,4'd0,0),
           cv(0,0,0,1,1,2'd3,2'd2,0,0,4'd0,0));
    run_wb("addx0", 32'h0020_8033,
           cv(0,0,0,0,0,0,0,0,0,4'd0,0),
           cv(0,0,0,1,0,0,0,0,0,4'd0,0));

    fd("lw2", 32'h0080_A283);
    ready = 1'b0;
    step();
    look("lw2.m", 4, cv(1,0,0,0,0,0,0,0,0,4'd0,0));
    #2;
    rst_n = 1'b0;
    #1;
    look("midrst", 0, 32'd0);
    check("midrst.cyc", cyc, 32'd0);
    check("midrst.ret", ret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    ncyc = 0;
    nret = 0;
    #1;
    check("midrst.idle", {29'd0, state}, 32'd0);
    step();
    check("midrst.fetch", {29'd0, state}, 32'd1);

    fd("lowbits", 32'h0020_8030);
    look("lowbits.t", 6, cv(0,0,0,0,0,0,0,0,0,4'd0,1));
    do_reset("r1");

    fd("ill", 32'hFFFF_FFFF);
    for (int i = 0; i < 12; i++) begin
      look("trap", 6, cv(0,0,0,0,0,0,0,0,0,4'd0,1));
      step();
    end
    cnt("trap");
    do_reset("r2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
